// File: rtl/det_pkg.sv
// Shared types and constants for the determinant scheduler and its datapath.
// Matrices are 25 signed 8-bit elements, row-major with n columns for an n x n size.
package det_pkg;

  localparam int ELEM_W = 8;
  localparam int MAT_W  = 200;
  localparam int DET_W  = 32;

  typedef enum logic [1:0] {
    SZ_2X2 = 2'b00,
    SZ_3X3 = 2'b01,
    SZ_4X4 = 2'b10,
    SZ_5X5 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Bits that carry real elements for a size code; everything above n*n elements is cleared.
  function automatic logic [MAT_W-1:0] size_mask(input logic [1:0] sz);
    logic [MAT_W-1:0] m;
    m = '0;
    unique case (sz)
      SZ_2X2:  m[31:0]  = '1;
      SZ_3X3:  m[71:0]  = '1;
      SZ_4X4:  m[127:0] = '1;
      default: m        = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/det_arb_rr2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module det_arb_rr2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    unique case (req_valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/determinante.sv
// Combinational determinant of a 2x2..5x5 signed 8-bit matrix, 32-bit wrapping result.
// The n x n input is embedded in a 5x5 identity so one 5x5 Laplace expansion serves every size.
module determinante
  import det_pkg::*;
(
  input  logic [MAT_W-1:0] matriz,
  input  logic [1:0]       sinalizador,
  output logic [DET_W-1:0] det
);

  typedef int m3_t [3][3];
  typedef int m4_t [4][4];
  typedef int m5_t [5][5];

  function automatic int det3(input m3_t a);
    return a[0][0] * (a[1][1] * a[2][2] - a[1][2] * a[2][1])
         - a[0][1] * (a[1][0] * a[2][2] - a[1][2] * a[2][0])
         + a[0][2] * (a[1][0] * a[2][1] - a[1][1] * a[2][0]);
  endfunction

  function automatic int det4(input m4_t a);
    m3_t s;
    int  acc;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++) s[r][k] = a[r+1][(k < c) ? k : k + 1];
      acc = (c % 2 == 0) ? acc + a[0][c] * det3(s) : acc - a[0][c] * det3(s);
    end
    return acc;
  endfunction

  function automatic int det5(input m5_t a);
    m4_t s;
    int  acc;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) s[r][k] = a[r+1][(k < c) ? k : k + 1];
      acc = (c % 2 == 0) ? acc + a[0][c] * det4(s) : acc - a[0][c] * det4(s);
    end
    return acc;
  endfunction

  m5_t a;
  int  n;

  always_comb begin
    n = int'(sinalizador) + 2;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r < n && c < n) a[r][c] = int'($signed(matriz[ELEM_W*(r*n+c) +: ELEM_W]));
        else                a[r][c] = (r == c) ? 1 : 0;
    det = DET_W'(det5(a));
  end

endmodule

// File: rtl/det_sched.sv
// Arbitrates two requesters onto one combinational determinant datapath, holds the operands
// for WAIT_CYCLES cycles (multicycle path) and returns the result over valid/ready.
module det_sched
  import det_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [MAT_W-1:0] req_matriz0,
  input  logic [1:0]       req_sinal0,
  input  logic [MAT_W-1:0] req_matriz1,
  input  logic [1:0]       req_sinal1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DET_W-1:0] out_det,
  output logic             out_id,
  output logic [1:0]       out_sinal,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [MAT_W-1:0] mat_q, mat_d;
  logic [1:0]       sz_q, sz_d;
  logic             id_q, id_d;
  logic             out_valid_q, out_valid_d;
  logic [DET_W-1:0] out_det_q, out_det_d;
  logic             out_id_q, out_id_d;
  logic [1:0]       out_sinal_q, out_sinal_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [1:0]       gnt;
  logic [1:0]       sel_sz;
  logic [MAT_W-1:0] sel_mat;
  logic [DET_W-1:0] det_w;

  det_arb_rr2 u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  determinante u_det (
    .matriz      (mat_q),
    .sinalizador (sz_q),
    .det         (det_w)
  );

  assign sel_sz  = gnt[1] ? req_sinal1 : req_sinal0;
  assign sel_mat = (gnt[1] ? req_matriz1 : req_matriz0) & size_mask(sel_sz);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mat_d        = mat_q;
    sz_d         = sz_q;
    id_d         = id_q;
    out_valid_d  = out_valid_q;
    out_det_d    = out_det_q;
    out_id_d     = out_id_q;
    out_sinal_d  = out_sinal_q;
    op_count_d   = op_count_q;
    req_ready    = 2'b00;
    unique case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          mat_d        = sel_mat;
          sz_d         = sel_sz;
          id_d         = gnt[1];
          last_grant_d = gnt[1];
          cnt_d        = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          out_det_d   = det_w;
          out_id_d    = id_q;
          out_sinal_d = sz_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      // NOTE: the wide operand register is reset too, so the datapath never sees X after reset.
      mat_q        <= '0;
      sz_q         <= '0;
      id_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_det_q    <= '0;
      out_id_q     <= 1'b0;
      out_sinal_q  <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mat_q        <= mat_d;
      sz_q         <= sz_d;
      id_q         <= id_d;
      out_valid_q  <= out_valid_d;
      out_det_q    <= out_det_d;
      out_id_q     <= out_id_d;
      out_sinal_q  <= out_sinal_d;
      op_count_q   <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_det   = out_det_q;
  assign out_id    = out_id_q;
  assign out_sinal = out_sinal_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule
